adder_arbiter4: RTL

Four-requester round-robin arbiter and sequencer sharing one 32-bit carry-select adder datapath (`select_adder32`). It accepts add/subtract operations from four independent valid/ready requesters and issues at most one per cycle to the shared adder. It returns each result through a single registered response port with backpressure. It sits between the execution-unit requesters and the adder, so the adder never needs duplicating per client.

---
 rtl/adder_arbiter4.sv | 119 +++++++++++
 1 files changed

// File: rtl/adder_arbiter4.sv
// Round-robin arbiter feeding four requesters into one shared
// 32-bit carry-select adder, with a registered, backpressured response.

module select_adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    localparam int BLK = 8;
    localparam int NB  = 32 / BLK;

    logic [NB:0] c;

    assign c[0] = cin;

    // Each block precomputes both carry-in outcomes; the ripple is only muxes.
    for (genvar i = 0; i < NB; i++) begin : g_blk
        logic [BLK:0] s0;
        logic [BLK:0] s1;

        assign s0 = {1'b0, a[i*BLK +: BLK]} + {1'b0, b[i*BLK +: BLK]};
        assign s1 = {1'b0, a[i*BLK +: BLK]} + {1'b0, b[i*BLK +: BLK]}
                  + {{BLK{1'b0}}, 1'b1};

        assign sum[i*BLK +: BLK] = c[i] ? s1[BLK-1:0] : s0[BLK-1:0];
        assign c[i+1]            = c[i] ? s1[BLK] : s0[BLK];
    end

    assign cout = c[NB];
endmodule

module adder_arbiter4 #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    input  logic [NREQ-1:0]       req_sub,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [1:0]            rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout
);
    logic [1:0]       rr_ptr;
    logic             slot_avail;
    logic [NREQ-1:0]  grant;
    logic [1:0]       gid;
    logic [1:0]       idx;
    logic             found;
    logic             xfer;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;
    logic [WIDTH-1:0] sum;
    logic             cout;

    assign slot_avail = !rsp_valid || rsp_ready;

    always_comb begin
        grant = '0;
        gid   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = rr_ptr + 2'(k);
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                gid        = idx;
                grant[idx] = 1'b1;
            end
        end
        // Held in reset, nothing may be accepted even though the slot is empty.
        if (!slot_avail || !rst_n) begin
            grant = '0;
        end
    end

    assign req_ready = grant;
    assign xfer      = |grant;

    assign op_a   = req_a[gid*WIDTH +: WIDTH];
    assign op_b   = req_sub[gid] ? ~req_b[gid*WIDTH +: WIDTH]
                                 : req_b[gid*WIDTH +: WIDTH];
    assign op_cin = req_sub[gid] | req_cin[gid];

    select_adder32 u_add (
        .a    (op_a),
        .b    (op_b),
        .cin  (op_cin),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rr_ptr    <= '0;
        end else if (xfer) begin
            rsp_valid <= 1'b1;
            rsp_id    <= gid;
            rsp_sum   <= sum;
            rsp_cout  <= cout;
            rr_ptr    <= gid + 2'd1;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end
endmodule
